// File: rtl/instr_sequencer.sv
// instr_sequencer: program counter and instruction-fetch stage.
// Fetches 16-bit words over a req/valid handshake, holds them in an
// instruction register, presents the fields for one EXEC cycle and
// computes the next PC from the decoder's PL/JB/BC and the A-bus value.
module instr_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  input  logic        pl,
  input  logic        jb,
  input  logic        bc,
  input  logic [7:0]  ad_out,
  output logic [6:0]  opcode,
  output logic [2:0]  dr,
  output logic [2:0]  sa,
  output logic [2:0]  sb,
  output logic [7:0]  constant_in,
  output logic        instr_valid,
  output logic [7:0]  pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [6:0] OP_HLT = 7'b1111111;

  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] ir_r;
  logic [7:0]  pc_r;
  logic [7:0]  pc_next_s;
  logic [7:0]  pc_target_s;
  logic        ir_load_s;
  logic        req_r;
  logic        valid_r;
  logic        halted_r;

  // Sign-extend the 6-bit branch offset {dr,sb} to 8 bits.
  function automatic logic [7:0] branch_offset(input logic [15:0] ir);
    return {{2{ir[8]}}, ir[8:6], ir[2:0]};
  endfunction

  // Select the PC that follows a non-halt EXEC from PL/JB/BC and the A-bus.
  always_comb begin
    pc_target_s = pc_r + 8'd1;
    if (!pl) begin
      pc_target_s = pc_r + 8'd1;
    end else if (jb) begin
      pc_target_s = ad_out;
    end else if (bc) begin
      if (ad_out == 8'd0) begin
        pc_target_s = pc_r + branch_offset(ir_r);
      end else begin
        pc_target_s = pc_r + 8'd1;
      end
    end else begin
      if (ad_out[7]) begin
        pc_target_s = pc_r + branch_offset(ir_r);
      end else begin
        pc_target_s = pc_r + 8'd1;
      end
    end
  end

  // Next-state, PC update and IR load decisions for the fetch/exec FSM.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    ir_load_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (run) begin
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (imem_valid) begin
          ir_load_s    = 1'b1;
          state_next_s = S_EXEC;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_EXEC: begin
        if (ir_r[15:9] == OP_HLT) begin
          state_next_s = S_HALT;
        end else begin
          pc_next_s = pc_target_s;
          if (run) begin
            state_next_s = S_FETCH;
          end else begin
            state_next_s = S_IDLE;
          end
        end
      end
      S_HALT: begin
        state_next_s = S_HALT;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State, PC, IR and registered status outputs; rst clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      pc_r     <= 8'd0;
      ir_r     <= 16'd0;
      req_r    <= 1'b0;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      pc_r     <= pc_next_s;
      if (ir_load_s) begin
        ir_r <= imem_rdata;
      end
      req_r    <= (state_next_s == S_FETCH);
      valid_r  <= (state_next_s == S_EXEC);
      halted_r <= (state_next_s == S_HALT);
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign instr_valid = valid_r;
  assign halted      = halted_r;
  assign opcode      = ir_r[15:9];
  assign dr          = ir_r[8:6];
  assign sa          = ir_r[5:3];
  assign sb          = ir_r[2:0];
  assign constant_in = {5'b00000, ir_r[2:0]};

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program-counter and instruction-fetch stage that sits directly upstream of the decoder/datapath CPU core. It fetches 16-bit instruction words from an instruction memory over a request/valid handshake and latches them into an instruction register. It then presents the opcode, dr, sa, sb and constant_in fields to the core for exactly one execute cycle. It computes the next PC from the decoder's PL/JB/BC outputs and the core's A-bus value (ad_out).

## Interface
Parameters:
- none; all widths are fixed (8-bit PC and data, 16-bit instruction).

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  start/continue enable
- imem_req  out  1  fetch request
- imem_addr  out  8  fetch address (equals pc)
- imem_valid  in  1  fetched word is valid this cycle
- imem_rdata  in  16  instruction word: [15:9] opcode, [8:6] dr, [5:3] sa, [2:0] sb
- pl  in  1  decoder PL (load PC on branch/jump)
- jb  in  1  decoder JB (1 = jump to register, 0 = conditional branch)
- bc  in  1  decoder BC (1 = branch on zero, 0 = branch on negative)
- ad_out  in  8  core A-bus value (R[sa])
- opcode  out  7  IR[15:9]
- dr, sa, sb  out  3 each  IR[8:6], IR[5:3], IR[2:0]
- constant_in  out  8  {5'b0, IR[2:0]}
- instr_valid  out  1  high only in EXEC; the top level ANDs it into RW and MW
- pc  out  8  current program counter
- halted  out  1  high in HALT

## Operation
- States: IDLE, FETCH, EXEC, HALT. After reset the block is in IDLE with pc=0, IR=0, and all outputs 0.
- IDLE:
  - imem_req=0.
  - If run=1, go to FETCH; otherwise stay.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until the handshake completes.
  - On a rising edge with imem_valid=1: IR <= imem_rdata, then go to EXEC.
  - Otherwise stay in FETCH.
  - imem_valid is ignored in all other states.
- EXEC (exactly one cycle):
  - instr_valid=1; the field outputs reflect IR.
  - If IR[15:9] = 7'b1111111 (HLT): pc is unchanged and the next state is HALT.
  - For every other opcode, pc is updated on the edge leaving EXEC:
    - pl=0: pc <= pc+1.
    - pl=1, jb=1: pc <= ad_out.
    - pl=1, jb=0, bc=1: if ad_out==0, pc <= pc + sext({dr,sb}); otherwise pc+1.
    - pl=1, jb=0, bc=0: if ad_out[7]==1, pc <= pc + sext({dr,sb}); otherwise pc+1.
  - Next state is FETCH if run=1, IDLE if run=0.
- HALT:
  - imem_req=0, instr_valid=0, halted=1.
  - Exit only via rst.
- Arithmetic:
  - The branch offset {dr,sb} is a 6-bit two's-complement value (-32..+31), sign-extended to 8 bits.
  - All PC arithmetic is modulo 256. 8'hFF+1 = 8'h00; 8'h02 + (-4) = 8'hFE.
- Output hold: the field outputs always reflect IR, even outside EXEC. Only instr_valid qualifies them.

## Timing
- Zero-wait memory (imem_valid=1 in the first FETCH cycle): 2 cycles per instruction (FETCH, EXEC).
- Each cycle imem_valid stays low adds one FETCH cycle.
- From rst deassertion with run=1: IDLE for 1 cycle, imem_req=1 on cycle 2, and the first instr_valid no earlier than cycle 3.
- pl, jb, bc and ad_out are sampled only on the edge ending EXEC. They are driven combinationally by the core from the presented fields in the same cycle.
- rst=1 on any edge (including mid-FETCH with a pending request, or during EXEC) forces IDLE, pc=0, IR=0. imem_req is 0 the following cycle, and no register/memory write is qualified.
- run falling mid-FETCH does not abort the fetch. It takes effect at the end of the following EXEC.

## Test plan
- Reset: hold rst 2 cycles with run=1 → pc=0, imem_req=0, instr_valid=0, halted=0, opcode=0; imem_req rises 1 cycle after rst falls.
- Straight-line, zero-wait: program of 4 non-branch words at addresses 0..3 → instr_valid pulses every 2nd cycle, pc goes 0,1,2,3,4, and opcode/dr/sa/sb/constant_in match each word during its pulse.
- Wait states: imem_valid delayed 3 cycles on address 1 → imem_req and imem_addr=1 stay stable for 4 FETCH cycles, then exactly one EXEC.
- Branches at pc=8:
  - bc=1, ad_out=0, offset 6'b111100 → pc=4.
  - Same with ad_out=5 → pc=9.
  - bc=0, ad_out=8'h80, offset +3 → pc=11.
  - pl=1, jb=1, ad_out=8'hFF → pc=8'hFF, then sequential → pc=0 (wrap).
- Halt: HLT word at address 2 → pc frozen at 2, halted=1, no further imem_req; rst returns the block to IDLE with pc=0.
- Reset mid-fetch: assert rst while imem_req=1 and imem_valid=0, then return imem_valid=1 one cycle later → the word is not latched, and IDLE is entered with pc=0.
